// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM family.
package dpram_pkg;

  // Clear sequencer states: IDLE is a one-cycle dispatch step after reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_t;

  // Same-port read-during-write selections.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/dpram_be_lane.sv
// One 8-bit byte lane: true dual-port storage with registered old-data reads.
module dpram_be_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [7:0]        din_a,
  output logic [7:0]        dout_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        din_b,
  output logic [7:0]        dout_b
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Both ports write and read in one process; the top never lets both ports
  // write the same address of this lane in the same cycle.
  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/dpram_be_gen.sv
// Dual-port byte-enable RAM with clear sweep, port-A-priority collision
// handling, cross-port write forwarding and optional output register.
module dpram_be_gen
  import dpram_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BYTES     = 4,
  parameter int OUT_REG   = 0,
  parameter int RDW_NEW   = 0,
  parameter int CROSS_FWD = 1,
  parameter int CLEAR_EN  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wren_a,
  input  logic                wren_b,
  input  logic [BYTES-1:0]    byteena_a,
  input  logic [BYTES-1:0]    byteena_b,
  input  logic [ADDR_W-1:0]   address_a,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [8*BYTES-1:0]  data_a,
  input  logic [8*BYTES-1:0]  data_b,
  output logic [8*BYTES-1:0]  q_a,
  output logic [8*BYTES-1:0]  q_b,
  output logic                ready,
  output logic                collision
);

  localparam int DW = 8*BYTES;

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              clr_wr;

  // Clear sequencer state and sweep counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic: IDLE dispatches, CLEAR walks every address once.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_IDLE:  state_nxt = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (&clr_cnt) state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign ready  = (state == ST_READY);
  assign clr_wr = (state == ST_CLEAR) && !reset;

  // ---- stage p0: write mux, A wins overlapping lanes on a shared address
  logic              addr_eq_p0;
  logic [BYTES-1:0]  wm_a_p0, wm_b_raw_p0, wm_b_p0, arr_we_a;
  logic [ADDR_W-1:0] arr_addr_a;
  logic [DW-1:0]     arr_din_a, rd_a_p1, rd_b_p1;

  assign addr_eq_p0  = (address_a == address_b);
  assign wm_a_p0     = (ready && wren_a) ? byteena_a : '0;
  assign wm_b_raw_p0 = (ready && wren_b) ? byteena_b : '0;
  assign wm_b_p0     = wm_b_raw_p0 & ~(addr_eq_p0 ? wm_a_p0 : '0);
  assign arr_we_a    = clr_wr ? '1 : wm_a_p0;
  assign arr_addr_a  = clr_wr ? clr_cnt : address_a;
  assign arr_din_a   = clr_wr ? '0 : data_a;

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    dpram_be_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clock  (clock),
      .we_a   (arr_we_a[i]),
      .addr_a (arr_addr_a),
      .din_a  (arr_din_a[8*i +: 8]),
      .dout_a (rd_a_p1[8*i +: 8]),
      .we_b   (wm_b_p0[i]),
      .addr_b (address_b),
      .din_b  (data_b[8*i +: 8]),
      .dout_b (rd_b_p1[8*i +: 8])
    );
  end

  // Collision pulse: both ports enabled an overlapping lane at one address.
  always_ff @(posedge clock) begin
    if (reset) collision <= 1'b0;
    else       collision <= addr_eq_p0 && (|(wm_a_p0 & wm_b_raw_p0));
  end

  // ---- stage p1: registered write context alongside the array read
  logic [ADDR_W-1:0] addr_a_p1, addr_b_p1;
  logic [DW-1:0]     data_a_p1, data_b_p1, mrg_a_p1, mrg_b_p1;
  logic [BYTES-1:0]  wm_a_p1, wm_b_raw_p1, wm_b_eff_p1;
  logic              addr_eq_p1, vld_p1;

  // Write context capture; no reset needed since vld_p1 qualifies it.
  always_ff @(posedge clock) begin
    addr_a_p1   <= address_a;
    addr_b_p1   <= address_b;
    data_a_p1   <= data_a;
    data_b_p1   <= data_b;
    wm_a_p1     <= wm_a_p0;
    wm_b_raw_p1 <= wm_b_raw_p0;
  end

  // Read-valid tracks whether the array was usable when the address was taken.
  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= ready;
  end

  assign addr_eq_p1  = (addr_a_p1 == addr_b_p1);
  assign wm_b_eff_p1 = wm_b_raw_p1 & ~(addr_eq_p1 ? wm_a_p1 : '0);

  // Per-lane merge: same-port new data first, cross-port forwarding on top.
  always_comb begin
    mrg_a_p1 = rd_a_p1;
    mrg_b_p1 = rd_b_p1;
    for (int i = 0; i < BYTES; i++) begin
      if (RDW_NEW != dpram_pkg::RDW_OLD && wm_a_p1[i])
        mrg_a_p1[8*i +: 8] = data_a_p1[8*i +: 8];
      if (RDW_NEW != dpram_pkg::RDW_OLD && wm_b_eff_p1[i])
        mrg_b_p1[8*i +: 8] = data_b_p1[8*i +: 8];
      if (CROSS_FWD != 0 && addr_eq_p1 && wm_b_raw_p1[i])
        mrg_a_p1[8*i +: 8] = wm_a_p1[i] ? data_a_p1[8*i +: 8] : data_b_p1[8*i +: 8];
      if (CROSS_FWD != 0 && addr_eq_p1 && wm_a_p1[i])
        mrg_b_p1[8*i +: 8] = data_a_p1[8*i +: 8];
    end
  end

  // ---- stage p2: optional output register
  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] q_a_p2, q_b_p2;
    logic          vld_p2;

    // Output data register.
    always_ff @(posedge clock) begin
      q_a_p2 <= mrg_a_p1;
      q_b_p2 <= mrg_b_p1;
    end

    // Output valid follows the read valid by one stage.
    always_ff @(posedge clock) begin
      if (reset) vld_p2 <= 1'b0;
      else       vld_p2 <= vld_p1;
    end

    assign q_a = vld_p2 ? q_a_p2 : '0;
    assign q_b = vld_p2 ? q_b_p2 : '0;
  end else begin : g_noreg
    assign q_a = vld_p1 ? mrg_a_p1 : '0;
    assign q_b = vld_p1 ? mrg_b_p1 : '0;
  end

endmodule

// File: tb/tb_dpram_be_gen.sv
// Directed bench: four instances share one stimulus stream and differ only in
// parameters (defaults / new-data no-forward / output register / no clear).
module tb_dpram_be_gen;

  localparam int AW = 4;
  localparam int NB = 4;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, wren_a, wren_b;
  logic [NB-1:0] byteena_a, byteena_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_a, data_b;

  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1, q_a2, q_b2, q_a3, q_b3;
  logic          rdy0, rdy1, rdy2, rdy3, col0, col1, col2, col3;

  dpram_be_gen #(.ADDR_W(AW), .BYTES(NB)) u0 (
    .clock(clock), .reset(reset), .wren_a(wren_a), .wren_b(wren_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a0), .q_b(q_b0), .ready(rdy0), .collision(col0));

  dpram_be_gen #(.ADDR_W(AW), .BYTES(NB), .RDW_NEW(1), .CROSS_FWD(0)) u1 (
    .clock(clock), .reset(reset), .wren_a(wren_a), .wren_b(wren_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a1), .q_b(q_b1), .ready(rdy1), .collision(col1));

  dpram_be_gen #(.ADDR_W(AW), .BYTES(NB), .OUT_REG(1)) u2 (
    .clock(clock), .reset(reset), .wren_a(wren_a), .wren_b(wren_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a2), .q_b(q_b2), .ready(rdy2), .collision(col2));

  dpram_be_gen #(.ADDR_W(AW), .BYTES(NB), .CLEAR_EN(0)) u3 (
    .clock(clock), .reset(reset), .wren_a(wren_a), .wren_b(wren_b),
    .byteena_a(byteena_a), .byteena_b(byteena_b), .address_a(address_a), .address_b(address_b),
    .data_a(data_a), .data_b(data_b), .q_a(q_a3), .q_b(q_b3), .ready(rdy3), .collision(col3));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          wa;
    logic [NB-1:0] bea;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          wb;
    logic [NB-1:0] beb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [DW-1:0] qa0, qb0, qa1, qb1;
    logic          col;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wren_a = 1'b0; wren_b = 1'b0;
    byteena_a = '0; byteena_b = '0;
    data_a = '0; data_b = '0;
  endtask

  task automatic wait_ready(input string name, input int exp0, input int exp3, input logic do_drop);
    int r0, r1, r2, r3;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (do_drop && c == 5) begin
        wren_a = 1'b1; byteena_a = 4'hF; address_a = 4'd0; data_a = 32'hA5A5A5A5;
        wren_b = 1'b1; byteena_b = 4'hF; address_b = 4'd0; data_b = 32'h5A5A5A5A;
      end else begin
        idle_inputs();
      end
      tick();
      if (do_drop && c == 5) begin
        check({name, "_col_not_ready"}, col0, 1'b0);
        check({name, "_col_ready_noclr"}, col3, 1'b1);
      end
      if (r0 == 0 && rdy0) r0 = c;
      if (r1 == 0 && rdy1) r1 = c;
      if (r2 == 0 && rdy2) r2 = c;
      if (r3 == 0 && rdy3) r3 = c;
      if (r0 != 0 && r1 != 0 && r2 != 0 && r3 != 0) break;
    end
    idle_inputs();
    check({name, "_ready_cyc_u0"}, r0, exp0);
    check({name, "_ready_cyc_u1"}, r1, exp0);
    check({name, "_ready_cyc_u2"}, r2, exp0);
    check({name, "_ready_cyc_u3"}, r3, exp3);
  endtask

  initial begin
    logic [DW-1:0] pqa, pqb;

    //            wa   bea   aa     da            wb   beb   ab     db             qa0           qb0           qa1           qb1          col
    vecs[0] = '{1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd3, 32'h00000000, 32'h00000000, 32'h11223344, 32'h11223344, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 4'h5, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd3, 32'h00000000, 32'h11223344, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 4'd3, 32'h00000000, 1'b0, 4'h0, 4'd3, 32'h00000000, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[3] = '{1'b1, 4'h3, 4'd7, 32'h01020304, 1'b1, 4'h6, 4'd7, 32'hF0F0F0F0, 32'h00F00300, 32'h00000304, 32'h00000304, 32'h00F00000, 1'b1};
    vecs[4] = '{1'b0, 4'h0, 4'd7, 32'h00000000, 1'b0, 4'h0, 4'd7, 32'h00000000, 32'h00F00304, 32'h00F00304, 32'h00F00304, 32'h00F00304, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 4'd2, 32'hDEADBEEF, 1'b0, 4'h0, 4'd9, 32'h00000000, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 4'd2, 32'h00000000, 1'b1, 4'hF, 4'd9, 32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[7] = '{1'b1, 4'hC, 4'd9, 32'hCAFE0000, 1'b0, 4'h0, 4'd9, 32'h00000000, 32'h12345678, 32'hCAFE5678, 32'hCAFE5678, 32'h12345678, 1'b0};
    vecs[8] = '{1'b0, 4'h0, 4'd0, 32'h00000000, 1'b0, 4'h0, 4'd9, 32'h00000000, 32'h00000000, 32'hCAFE5678, 32'h00000000, 32'hCAFE5678, 1'b0};
    vecs[9] = '{1'b0, 4'h0, 4'd3, 32'h00000000, 1'b0, 4'h0, 4'd5, 32'h00000000, 32'h11BB33DD, 32'h00000000, 32'h11BB33DD, 32'h00000000, 1'b0};

    // Reset state.
    reset = 1'b1; idle_inputs(); address_a = '0; address_b = '0;
    tick(); tick();
    check("rst_ready", rdy0, 1'b0);
    check("rst_q_a", q_a0, 32'h0);
    check("rst_q_b", q_b0, 32'h0);
    check("rst_col", col0, 1'b0);
    check("rst_q_a_oreg", q_a2, 32'h0);
    reset = 1'b0;

    // Clear sweep timing; colliding write at cycle 5 is dropped while clearing.
    wait_ready("clr", 17, 1, 1'b1);

    // Whole array reads zero after the clear, including the dropped write address.
    for (int i = 0; i < 16; i++) begin
      address_a = AW'(i);
      address_b = AW'(15 - i);
      tick();
      check($sformatf("sweep_q_a_%0d", i), q_a0, 32'h0);
      check($sformatf("sweep_q_b_%0d", 15 - i), q_b0, 32'h0);
    end

    // Table-driven vectors; the output-register instance lags by one vector.
    pqa = '0; pqb = '0;
    for (int k = 0; k < 10; k++) begin
      wren_a = vecs[k].wa; byteena_a = vecs[k].bea; address_a = vecs[k].aa; data_a = vecs[k].da;
      wren_b = vecs[k].wb; byteena_b = vecs[k].beb; address_b = vecs[k].ab; data_b = vecs[k].db;
      tick();
      check($sformatf("v%0d_u0_q_a", k), q_a0, vecs[k].qa0);
      check($sformatf("v%0d_u0_q_b", k), q_b0, vecs[k].qb0);
      check($sformatf("v%0d_u0_col", k), col0, vecs[k].col);
      check($sformatf("v%0d_u1_q_a", k), q_a1, vecs[k].qa1);
      check($sformatf("v%0d_u1_q_b", k), q_b1, vecs[k].qb1);
      check($sformatf("v%0d_u1_col", k), col1, vecs[k].col);
      check($sformatf("v%0d_u2_q_a", k), q_a2, pqa);
      check($sformatf("v%0d_u2_q_b", k), q_b2, pqb);
      check($sformatf("v%0d_u2_col", k), col2, vecs[k].col);
      if (k == 2) begin
        check("v2_u3_q_a", q_a3, 32'h11BB33DD);
        check("v2_u3_q_b", q_b3, 32'h11BB33DD);
      end
      pqa = vecs[k].qa0;
      pqb = vecs[k].qb0;
    end
    idle_inputs();

    // Reset mid-clear: outputs gated while clearing, sweep restarts from 0.
    reset = 1'b1; tick(); reset = 1'b0;
    address_a = 4'd3; address_b = 4'd9;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c <= 3) begin
        check($sformatf("clr_gate_q_a_c%0d", c), q_a0, 32'h0);
        check($sformatf("clr_gate_q_b_c%0d", c), q_b0, 32'h0);
      end
    end
    check("midclr_ready_low", rdy0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready("reclr", 17, 1, 1'b0);

    // Previously written words are zero after the restarted sweep.
    address_a = 4'd9; address_b = 4'd7;
    tick();
    check("reclr_addr9", q_a0, 32'h0);
    check("reclr_addr7", q_b0, 32'h0);

    // Write then read on the other port: 1-cycle vs 2-cycle latency.
    wren_a = 1'b1; byteena_a = 4'hF; address_a = 4'd1; data_a = 32'h0BADF00D; address_b = 4'd4;
    tick();
    idle_inputs(); address_b = 4'd1;
    tick();
    check("lat1_q_b", q_b0, 32'h0BADF00D);
    check("lat2_q_b_early", q_b2, 32'h0);
    tick();
    check("lat2_q_b", q_b2, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
